mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between instruction fetch and the load/store traffic leaving the execute stage.
- Sequences each access as a command followed by a wait for `mem_ready`.
- Generates byte strobes from the RISC-V funct3 size code and sign- or zero-extends load data.
- Drives the pipeline-wide `halt` that freezes the execute stage while a load or store is outstanding.

---
 rtl/mem_pkg.sv | 50 +++++
 rtl/mem_port_arbiter_load_align.sv | 29 ++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the unified memory port: funct3 size codes, arbiter states
// and the registered command payload presented to the memory.
package mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LS_BUSY = 2'd1,
    IF_BUSY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZC_B = 2'd0,
    SZC_H = 2'd1,
    SZC_W = 2'd2
  } size_cls_t;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN-1:0]   wdata;
  } mem_cmd_t;

  // Context of the outstanding load/store needed when its data returns.
  typedef struct packed {
    logic       we;
    logic [1:0] off;
    logic [2:0] size;
  } ls_ctx_t;

  // Unknown size codes collapse to word accesses.
  function automatic size_cls_t size_class(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: return SZC_B;
      SZ_H, SZ_HU: return SZC_H;
      SZ_W:        return SZC_W;
      default:     return SZC_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_load_align.sv
// Selects the addressed byte/halfword of a memory word and sign- or
// zero-extends it according to the funct3 size code.
module load_align
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rdata,
  input  logic [1:0]       i_off,
  input  logic [2:0]       i_size,
  output logic [WIDTH-1:0] o_data
);

  logic [7:0]         w_byte;
  logic [WIDTH/2-1:0] w_half;
  logic               w_sext;

  always_comb begin
    w_byte = i_rdata[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_rdata[WIDTH-1:WIDTH/2] : i_rdata[WIDTH/2-1:0];
    w_sext = ~i_size[2];
    case (size_class(i_size))
      SZC_B:   o_data = {{(WIDTH-8){w_sext & w_byte[7]}}, w_byte};
      SZC_H:   o_data = {{(WIDTH/2){w_sext & w_half[WIDTH/2-1]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// issuing one command per access and stalling execute while a load/store waits.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  input  logic             if_flush,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             ls_rd_en,
  input  logic             ls_wr_en,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wr_data,
  input  logic [2:0]       ls_size,
  output logic             ls_done,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             ls_misalign,
  output logic             halt,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  state_t    r_state, w_state_nxt;
  mem_cmd_t  r_cmd, w_cmd_nxt;
  ls_ctx_t   r_ctx, w_ctx_nxt;
  logic      r_mem_en, w_mem_en_nxt;
  logic      r_mis_done, w_mis_nxt;
  logic      r_flush, w_flush_nxt;

  size_cls_t         w_cls;
  logic              w_ls_req;
  logic              w_ls_mis;
  logic              w_ls_fin;
  logic              w_if_fin;
  logic [STRB_W-1:0] w_st_strb;
  logic [XLEN-1:0]   w_st_data;
  logic [WIDTH-1:0]  w_ld_ext;

  // A request still held during its misalign-done cycle must not be re-taken.
  assign w_cls    = size_class(ls_size);
  assign w_ls_req = (ls_rd_en | ls_wr_en) & ~r_mis_done;
  assign w_ls_mis = ((w_cls == SZC_H) & ls_addr[0]) |
                    ((w_cls == SZC_W) & (ls_addr[1:0] != 2'b00));

  // Store lane placement and byte strobes.
  always_comb begin
    w_st_strb = 4'b1111;
    w_st_data = ls_wr_data;
    case (w_cls)
      SZC_B: begin
        w_st_strb = STRB_W'(4'b0001 << ls_addr[1:0]);
        w_st_data = XLEN'(ls_wr_data[7:0]) << {ls_addr[1:0], 3'b000};
      end
      SZC_H: begin
        w_st_strb = STRB_W'(4'b0011 << ls_addr[1:0]);
        w_st_data = XLEN'(ls_wr_data[15:0]) << {ls_addr[1:0], 3'b000};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_ctx      <= '0;
      r_mem_en   <= 1'b0;
      r_mis_done <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd      <= w_cmd_nxt;
      r_ctx      <= w_ctx_nxt;
      r_mem_en   <= w_mem_en_nxt;
      r_mis_done <= w_mis_nxt;
      r_flush    <= w_flush_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_nxt    = r_cmd;
    w_ctx_nxt    = r_ctx;
    w_mem_en_nxt = 1'b0;
    w_mis_nxt    = 1'b0;
    w_flush_nxt  = r_flush;
    w_ls_fin     = 1'b0;
    w_if_fin     = 1'b0;
    case (r_state)
      IDLE: begin
        w_flush_nxt = 1'b0;
        if (w_ls_req) begin
          if (w_ls_mis) begin
            w_mis_nxt = 1'b1;
          end else begin
            w_mem_en_nxt    = 1'b1;
            w_cmd_nxt.we    = ls_wr_en;
            w_cmd_nxt.addr  = ls_addr & ~XLEN'(3);
            w_cmd_nxt.wstrb = ls_wr_en ? w_st_strb : '0;
            w_cmd_nxt.wdata = ls_wr_en ? w_st_data : '0;
            w_ctx_nxt       = '{we: ls_wr_en, off: ls_addr[1:0], size: ls_size};
            w_state_nxt     = LS_BUSY;
          end
        end else if (if_req) begin
          w_mem_en_nxt    = 1'b1;
          w_cmd_nxt.we    = 1'b0;
          w_cmd_nxt.addr  = if_addr & ~XLEN'(3);
          w_cmd_nxt.wstrb = '0;
          w_cmd_nxt.wdata = '0;
          w_state_nxt     = IF_BUSY;
        end
      end
      LS_BUSY: begin
        if (mem_ready) begin
          w_ls_fin    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      IF_BUSY: begin
        if (if_flush) begin
          w_flush_nxt = 1'b1;
        end
        if (mem_ready) begin
          w_if_fin    = ~(r_flush | if_flush);
          w_flush_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  load_align #(.WIDTH(WIDTH)) u_load_align (
    .i_rdata (mem_rdata),
    .i_off   (r_ctx.off),
    .i_size  (r_ctx.size),
    .o_data  (w_ld_ext)
  );

  assign ls_done     = r_mis_done | w_ls_fin;
  assign ls_misalign = r_mis_done;
  assign ls_rdata    = (w_ls_fin & ~r_ctx.we) ? w_ld_ext : '0;
  assign if_valid    = w_if_fin;
  assign if_rdata    = mem_rdata;
  assign halt        = (ls_rd_en | ls_wr_en) & ~ls_done;

  assign mem_en    = r_mem_en;
  assign mem_we    = r_cmd.we;
  assign mem_addr  = r_cmd.addr;
  assign mem_wstrb = r_cmd.wstrb;
  assign mem_wdata = r_cmd.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single load/store
// transactions plus hand sequences for contention, flush and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_rd_en, ls_wr_en, ls_done, ls_misalign, halt;
  logic [31:0] ls_addr, ls_wr_data, ls_rdata;
  logic [2:0]  ls_size;
  logic        mem_en, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_rd_en(ls_rd_en), .ls_wr_en(ls_wr_en), .ls_addr(ls_addr),
    .ls_wr_data(ls_wr_data), .ls_size(ls_size),
    .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_misalign(ls_misalign),
    .halt(halt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] mrd;
    int          dly;    // mem_ready arrives in cycle 1+dly
    logic        mis;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] wexp;   // expected data on the enabled lanes
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_rd_en = 1'b0; ls_wr_en = 1'b0; ls_addr = '0; ls_wr_data = '0; ls_size = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  task automatic run_vec(input int i);
    vec_t  v;
    string t;
    v = vecs[i];
    t = $sformatf("v%0d", i);
    step();
    ls_rd_en = v.rd; ls_wr_en = v.wr; ls_addr = v.addr;
    ls_wr_data = v.wdata; ls_size = v.size;
    @(negedge clk);
    chk({t, " halt c0"}, 32'(halt), 32'd1);
    step();
    @(negedge clk);
    if (v.mis) begin
      chk({t, " mis mem_en"}, 32'(mem_en), 32'd0);
      chk({t, " mis done"}, {30'd0, ls_done, ls_misalign}, 32'd3);
      chk({t, " mis rdata"}, ls_rdata, 32'd0);
      chk({t, " mis halt"}, 32'(halt), 32'd0);
    end else begin
      chk({t, " mem_en"}, 32'(mem_en), 32'd1);
      chk({t, " mem_we"}, 32'(mem_we), 32'(v.wr));
      chk({t, " mem_addr"}, mem_addr, v.maddr);
      chk({t, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.strb));
      chk({t, " mem_wdata"}, mem_wdata & lane_mask(v.strb), v.wexp);
      for (int k = 1; k < v.dly; k++) begin
        step();
        @(negedge clk);
        chk({t, " wait halt/en"}, {30'd0, halt, mem_en}, 32'd2);
      end
      step();
      mem_ready = 1'b1; mem_rdata = v.mrd;
      @(negedge clk);
      chk({t, " done"}, {29'd0, ls_done, ls_misalign, halt}, 32'd4);
      chk({t, " rdata"}, ls_rdata, v.rexp);
    end
    step();
    idle_inputs();
    @(negedge clk);
    chk({t, " after done"}, {30'd0, ls_done, mem_en}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            rd    wr    addr          wdata         sz    mrd           dly mis   maddr         strb     wexp          rexp
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,        3'd2, 32'hDEADBEEF, 2, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0103, 32'h0000_00A5,3'd0, 32'h0,        1, 1'b0, 32'h0000_0100, 4'b1000, 32'hA500_0000, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0202, 32'h0,        3'd1, 32'h8001_1234,1, 1'b0, 32'h0000_0200, 4'b0000, 32'h0,        32'hFFFF_8001};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0202, 32'h0,        3'd5, 32'h8001_1234,3, 1'b0, 32'h0000_0200, 4'b0000, 32'h0,        32'h0000_8001};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0101, 32'h0,        3'd0, 32'h1234_8056,1, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0103, 32'h0,        3'd4, 32'hF000_0000,1, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00F0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0206, 32'h1234_BEEF,3'd1, 32'h0,        2, 1'b0, 32'h0000_0204, 4'b1100, 32'hBEEF_0000, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0300, 32'hCAFE_F00D,3'd2, 32'h0,        1, 1'b0, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0102, 32'h1111_2222,3'd2, 32'h0,        1, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0105, 32'h0,        3'd1, 32'h0,        1, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,        3'd3, 32'h0102_0304,1, 1'b0, 32'h0000_0108, 4'b0000, 32'h0,        32'h0102_0304};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_010A, 32'h0,        3'd7, 32'h0,        1, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        3'd0, 32'h0000_007F,1, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_007F};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0101, 32'h0000_003C,3'd0, 32'h0,        1, 1'b0, 32'h0000_0100, 4'b0010, 32'h0000_3C00, 32'h0};

    idle_inputs();
    reset = 1'b1;
    step(); step();
    @(negedge clk);
    chk("reset ctrl", {27'd0, mem_en, mem_we, ls_done, ls_misalign, if_valid}, 32'd0);
    chk("reset wstrb", 32'(mem_wstrb), 32'd0);
    chk("reset addr", mem_addr, 32'd0);
    chk("reset wdata", mem_wdata, 32'd0);
    chk("reset halt", 32'(halt), 32'd0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i);

    // Plain fetch, earliest completion
    step(); if_req = 1'b1; if_addr = 32'h0000_0040;
    @(negedge clk); chk("if halt", 32'(halt), 32'd0);
    step(); @(negedge clk);
    chk("if cmd", {31'd0, mem_en}, 32'd1);
    chk("if we", 32'(mem_we), 32'd0);
    chk("if addr", mem_addr, 32'h0000_0040);
    step(); mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("if valid", 32'(if_valid), 32'd1);
    chk("if rdata", if_rdata, 32'h0000_0013);
    step(); idle_inputs();

    // Contention: load wins, fetch follows the cycle after ls_done
    step();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    ls_rd_en = 1'b1; ls_addr = 32'h0000_0104; ls_size = 3'd2;
    step(); @(negedge clk);
    chk("cont ld cmd", {31'd0, mem_en}, 32'd1);
    chk("cont ld addr", mem_addr, 32'h0000_0104);
    step(); mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("cont ld done", {30'd0, ls_done, if_valid}, 32'd2);
    chk("cont ld rdata", ls_rdata, 32'h5555_AAAA);
    step(); ls_rd_en = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("cont gap en", 32'(mem_en), 32'd0);
    step(); @(negedge clk);
    chk("cont if cmd", {31'd0, mem_en}, 32'd1);
    chk("cont if addr", mem_addr, 32'h0000_0080);
    step(); mem_ready = 1'b1; mem_rdata = 32'h00A0_0093;
    @(negedge clk);
    chk("cont if valid", 32'(if_valid), 32'd1);
    chk("cont if rdata", if_rdata, 32'h00A0_0093);
    step(); idle_inputs();

    // Flush before data returns: data dropped, next fetch unaffected
    step(); if_req = 1'b1; if_addr = 32'h0000_0044;
    step();
    step(); if_flush = 1'b1; if_req = 1'b0;
    step(); if_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("flush drop", 32'(if_valid), 32'd0);
    step(); mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0048;
    @(negedge clk);
    chk("flush idle en", 32'(mem_en), 32'd0);
    step(); @(negedge clk);
    chk("flush next addr", mem_addr, 32'h0000_0048);
    step(); mem_ready = 1'b1; mem_rdata = 32'h0000_0073;
    @(negedge clk);
    chk("flush next valid", 32'(if_valid), 32'd1);
    step(); idle_inputs();

    // Flush in the same cycle as mem_ready
    step(); if_req = 1'b1; if_addr = 32'h0000_004C;
    step();
    step(); mem_ready = 1'b1; if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("flush same cyc", 32'(if_valid), 32'd0);
    step(); idle_inputs();

    // Reset mid load, then a late mem_ready
    step(); ls_rd_en = 1'b1; ls_addr = 32'h0000_0110; ls_size = 3'd2;
    step();
    step(); reset = 1'b1; ls_rd_en = 1'b0;
    step(); reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rst late ready", {29'd0, ls_done, if_valid, mem_en}, 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    step(); mem_ready = 1'b0;
    @(negedge clk);
    chk("rst idle en", 32'(mem_en), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
